// File: rtl/mux_rr_arbiter_2x1.sv
// Two-requester round-robin arbiter steering a shared 2:1 select; holds a grant
// for up to MAX_BURST beats. Optional per-requester beat counters: MUX_RR_ARB_STATS_EN.
module mux_rr_arbiter_2x1 #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in0_valid,
    input  logic [DATA_W-1:0] in0_data,
    output logic              in0_ready,
    input  logic              in1_valid,
    input  logic [DATA_W-1:0] in1_data,
    output logic              in1_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              sel,
    output logic              busy
`ifdef MUX_RR_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  beats0,
    output logic [CNT_W-1:0]  beats1
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

    if (MAX_BURST < 1 || MAX_BURST > 255 || CNT_W < 1) begin : g_bad_params
        $error("mux_rr_arbiter_2x1: MAX_BURST must be 1..255 and CNT_W >= 1");
    end

    state_t     state_q, state_d;
    logic       prio_q, prio_d;
    logic       sel_q, sel_d;
    logic [7:0] beat_cnt_q, beat_cnt_d;

    logic in_grant;
    logic grant_valid;
    logic other_valid;
    logic xfer;

    assign in_grant    = (state_q == GRANT0) || (state_q == GRANT1);
    assign grant_valid = (state_q == GRANT1) ? in1_valid : in0_valid;
    assign other_valid = (state_q == GRANT1) ? in0_valid : in1_valid;
    assign xfer        = in_grant && grant_valid && out_ready;

    // NOTE: reset is synchronous, so it lives inside the clocked branch rather
    // than in the sensitivity list; all sequential state uses <= only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            prio_q     <= 1'b0;
            sel_q      <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            sel_q      <= sel_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // NOTE: every output of a combinational block gets a default first so no
    // path through the case statement can infer a latch.
    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in0_valid && in1_valid) begin
                    state_d = prio_q ? GRANT1 : GRANT0;
                end else if (in0_valid) begin
                    state_d = GRANT0;
                end else if (in1_valid) begin
                    state_d = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                // Release when the burst is exhausted or the owner goes idle;
                // hand straight to the other side if it is waiting.
                if (!grant_valid || (xfer && beat_cnt_q == LAST_BEAT)) begin
                    beat_cnt_d = '0;
                    prio_d     = (state_q == GRANT0);
                    if (other_valid) begin
                        state_d = (state_q == GRANT0) ? GRANT1 : GRANT0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (xfer) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Select follows the next grant and holds its last value through IDLE.
    always_comb begin
        sel_d = sel_q;
        if (state_d == GRANT1) begin
            sel_d = 1'b1;
        end else if (state_d == GRANT0) begin
            sel_d = 1'b0;
        end
    end

    always_comb begin
        out_valid = 1'b0;
        in0_ready = 1'b0;
        in1_ready = 1'b0;
        busy      = 1'b0;
        out_data  = sel_q ? in1_data : in0_data;
        if (reset) begin
            out_data = in0_data;
        end else begin
            unique case (state_q)
                GRANT0: begin
                    out_valid = in0_valid;
                    in0_ready = out_ready;
                    busy      = 1'b1;
                end
                GRANT1: begin
                    out_valid = in1_valid;
                    in1_ready = out_ready;
                    busy      = 1'b1;
                end
                default: begin
                    out_valid = 1'b0;
                end
            endcase
        end
    end

    assign sel = sel_q;

`ifdef MUX_RR_ARB_STATS_EN
    logic [CNT_W-1:0] beats0_q, beats1_q;

    // Saturating accepted-beat counters, one per requester.
    always_ff @(posedge clk) begin
        if (reset) begin
            beats0_q <= '0;
            beats1_q <= '0;
        end else begin
            if (xfer && state_q == GRANT0 && beats0_q != '1) begin
                beats0_q <= beats0_q + 1'b1;
            end
            if (xfer && state_q == GRANT1 && beats1_q != '1) begin
                beats1_q <= beats1_q + 1'b1;
            end
        end
    end

    assign beats0 = beats0_q;
    assign beats1 = beats1_q;
`endif

endmodule

// File: tb/tb_mux_rr_arbiter_2x1.sv
// Self-checking bench for mux_rr_arbiter_2x1: table of single-grant vectors,
// then scoreboarded multi-cycle sequences; stats check when MUX_RR_ARB_STATS_EN is set.
module tb_mux_rr_arbiter_2x1;

    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              in0_valid, in1_valid, out_ready;
    logic [DATA_W-1:0] in0_data, in1_data;
    logic              in0_ready, in1_ready, out_valid, sel, busy;
    logic [DATA_W-1:0] out_data;
`ifdef MUX_RR_ARB_STATS_EN
    logic [3:0]        beats0, beats1;
`endif

    mux_rr_arbiter_2x1 #(
        .DATA_W(DATA_W),
        .MAX_BURST(4),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in0_valid(in0_valid),
        .in0_data(in0_data),
        .in0_ready(in0_ready),
        .in1_valid(in1_valid),
        .in1_data(in1_data),
        .in1_ready(in1_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .sel(sel),
        .busy(busy)
`ifdef MUX_RR_ARB_STATS_EN
        ,
        .beats0(beats0),
        .beats1(beats1)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       src;
        logic [7:0] data;
    } beat_t;

    typedef struct {
        logic v0, v1, ordy;
        logic busy, sel, r0, r1, ov;
    } vec_t;

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];
    beat_t mon_e;
    logic  mon_en   = 1'b0;
    logic  auto_inc = 1'b0;
    int    hs0 = 0;
    int    hs1 = 0;
    vec_t  tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic src, input logic [7:0] data);
        beat_t b;
        b.src  = src;
        b.data = data;
        exp_q.push_back(b);
    endtask

    // Called at a negedge: records handshakes, advances to just after the next posedge.
    task automatic next_cycle();
        logic h0, h1;
        h0 = in0_valid && in0_ready;
        h1 = in1_valid && in1_ready;
        @(posedge clk);
        #1;
        if (h0) begin
            hs0++;
            if (auto_inc) in0_data++;
        end
        if (h1) begin
            hs1++;
            if (auto_inc) in1_data++;
        end
    endtask

    task automatic do_reset();
        mon_en    = 1'b0;
        reset     = 1'b1;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        out_ready = 1'b0;
        auto_inc  = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            next_cycle();
        end
        check(name, exp_q.size(), 0);
        mon_en = 1'b0;
    endtask

    // Scoreboard monitor: every accepted output beat must match the next expected one.
    always @(negedge clk) begin
        if (mon_en && !reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_beat", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_src", sel, mon_e.src);
                check("sb_data", out_data, mon_e.data);
                check("sb_ready", sel ? in1_ready : in0_ready, 1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0;
        in0_data = '0; in1_data = '0;

        // v0 v1 ordy | busy sel r0 r1 ov  (state one cycle after valids appear)
        tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

        for (int i = 0; i < 6; i++) begin
            reset = 1'b1; in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0;
            in0_data = 8'(8'h10 + i);
            in1_data = 8'(8'h80 + i);
            @(posedge clk);
            #1;
            @(negedge clk);
            check($sformatf("tbl%0d_rst_out_valid", i), out_valid, 0);
            check($sformatf("tbl%0d_rst_busy", i), busy, 0);
            check($sformatf("tbl%0d_rst_sel", i), sel, 0);
            check($sformatf("tbl%0d_rst_out_data", i), out_data, in0_data);
            reset = 1'b0;
            in0_valid = tbl[i].v0; in1_valid = tbl[i].v1; out_ready = tbl[i].ordy;
            #1;
            check($sformatf("tbl%0d_idle_busy", i), busy, 0);
            check($sformatf("tbl%0d_idle_out_valid", i), out_valid, 0);
            check($sformatf("tbl%0d_idle_readys", i), {in0_ready, in1_ready}, 0);
            @(posedge clk);
            #1;
            @(negedge clk);
            check($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
            check($sformatf("tbl%0d_sel", i), sel, tbl[i].sel);
            check($sformatf("tbl%0d_in0_ready", i), in0_ready, tbl[i].r0);
            check($sformatf("tbl%0d_in1_ready", i), in1_ready, tbl[i].r1);
            check($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].ov);
            check($sformatf("tbl%0d_out_data", i), out_data, tbl[i].sel ? in1_data : in0_data);
            in0_valid = 1'b0; in1_valid = 1'b0;
        end

        // Single requester: 4-beat burst, one-cycle IDLE bubble, then re-grant.
        do_reset();
        mon_en = 1'b1;
        in0_valid = 1'b1; in0_data = 8'hA5; in1_data = 8'h3C; out_ready = 1'b1;
        repeat (4) push(1'b0, 8'hA5);
        @(negedge clk);
        check("a_c0_busy", busy, 0);
        check("a_c0_in0_ready", in0_ready, 0);
        next_cycle();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check("a_c1_busy", busy, 1);
                check("a_c1_sel", sel, 0);
                check("a_c1_in0_ready", in0_ready, 1);
                check("a_c1_out_data", out_data, 8'hA5);
            end
            next_cycle();
        end
        @(negedge clk);
        check("a_bubble_busy", busy, 0);
        check("a_bubble_in0_ready", in0_ready, 0);
        next_cycle();
        push(1'b0, 8'hA5);
        @(negedge clk);
        check("a_regrant_busy", busy, 1);
        check("a_regrant_sel", sel, 0);
        next_cycle();
        drain("a_drain");

        // Both continuously valid: 0 x4, 1 x4, 0 x4 with no bubble.
        do_reset();
        mon_en = 1'b1; auto_inc = 1'b1;
        in0_data = 8'h00; in1_data = 8'h40;
        in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) push(1'b0, 8'(k));
        for (int k = 0; k < 4; k++) push(1'b1, 8'(8'h40 + k));
        for (int k = 0; k < 4; k++) push(1'b0, 8'(4 + k));
        @(negedge clk);
        next_cycle();
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check($sformatf("b_busy_%0d", k), busy, 1);
            check($sformatf("b_sel_%0d", k), sel, (k / 4) % 2);
            next_cycle();
        end
        drain("b_drain");

        // Both valid from reset; requester 0 drops after 2 beats, grant moves without a bubble.
        do_reset();
        mon_en = 1'b1; auto_inc = 1'b1;
        in0_data = 8'h20; in1_data = 8'h60;
        in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b1;
        push(1'b0, 8'h20); push(1'b0, 8'h21); push(1'b1, 8'h60);
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        check("c_first_sel", sel, 0);
        check("c_first_busy", busy, 1);
        next_cycle();
        @(negedge clk);
        next_cycle();
        in0_valid = 1'b0;
        @(negedge clk);
        check("c_drop_busy", busy, 1);
        check("c_drop_out_valid", out_valid, 0);
        check("c_drop_in1_ready", in1_ready, 0);
        next_cycle();
        @(negedge clk);
        check("c_switch_sel", sel, 1);
        check("c_switch_in1_ready", in1_ready, 1);
        next_cycle();
        drain("c_drain");

        // GRANT1 stalled 10 cycles with requester 0 waiting, then the full burst resumes.
        do_reset();
        mon_en = 1'b1; auto_inc = 1'b1;
        in1_data = 8'hC0; in0_data = 8'h50;
        in1_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        next_cycle();
        in0_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("d_stall_sel_%0d", k), sel, 1);
            check($sformatf("d_stall_readys_%0d", k), {in0_ready, in1_ready}, 0);
            next_cycle();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) push(1'b1, 8'(8'hC0 + k));
        push(1'b0, 8'h50); push(1'b0, 8'h51);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("d_resume_sel_%0d", k), sel, (k < 4) ? 1 : 0);
            next_cycle();
        end
        drain("d_drain");

        // Reset during the third beat of GRANT0: beat refused, burst count restarts.
        do_reset();
        mon_en = 1'b1; auto_inc = 1'b1;
        in0_data = 8'h70; in0_valid = 1'b1; out_ready = 1'b1;
        push(1'b0, 8'h70); push(1'b0, 8'h71);
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        check("e_rst_in0_ready", in0_ready, 0);
        check("e_rst_out_valid", out_valid, 0);
        check("e_rst_busy", busy, 0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("e_post_busy", busy, 0);
        check("e_post_sel", sel, 0);
        check("e_post_in0_ready", in0_ready, 0);
        next_cycle();
        for (int k = 0; k < 4; k++) push(1'b0, 8'(8'h72 + k));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("e_burst_busy_%0d", k), busy, 1);
            next_cycle();
        end
        @(negedge clk);
        check("e_full_burst_bubble", busy, 0);
        next_cycle();
        drain("e_drain");

`ifdef MUX_RR_ARB_STATS_EN
        // 20 beats from requester 1 saturate a 4-bit counter at 15.
        do_reset();
        @(negedge clk);
        check("f_rst_beats0", beats0, 0);
        check("f_rst_beats1", beats1, 0);
        mon_en = 1'b1; auto_inc = 1'b1;
        in1_data = 8'h00; in1_valid = 1'b1; out_ready = 1'b1;
        hs1 = 0;
        for (int k = 0; k < 20; k++) push(1'b1, 8'(k));
        begin
            logic mid_done;
            mid_done = 1'b0;
            for (int c = 0; c < 80 && hs1 < 20; c++) begin
                @(negedge clk);
                next_cycle();
                if (hs1 == 10 && !mid_done) begin
                    check("f_mid_beats1", beats1, 10);
                    mid_done = 1'b1;
                end
            end
        end
        in1_valid = 1'b0;
        check("f_handshakes", hs1, 20);
        @(negedge clk);
        check("f_sat_beats1", beats1, 15);
        check("f_beats0", beats0, 0);
        next_cycle();
        drain("f_drain");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter_2x1.md
Name: mux_rr_arbiter_2x1

Overview:
- Round-robin arbiter that shares one 2:1 select datapath between two valid/ready source channels and drives one output channel.
- Holds a grant for a burst of up to MAX_BURST beats, then rotates priority.
- Exposes the registered select so downstream 2x1 mux instances can be steered in lockstep.
- Sits between two producers and a single shared consumer or resource.

Parameters:
- DATA_W, 8, width of each data channel.
- MAX_BURST, 4, maximum beats accepted per grant before forced rotation; legal range 1 to 255.
- CNT_W, 16, width of per-requester beat counters; used only with the optional feature.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in0_valid  input  1  requester 0 has a beat.
- in0_data  input  DATA_W  requester 0 payload.
- in0_ready  output  1  requester 0 beat accepted this cycle when high with in0_valid.
- in1_valid  input  1  requester 1 has a beat.
- in1_data  input  DATA_W  requester 1 payload.
- in1_ready  output  1  requester 1 beat accepted this cycle when high with in1_valid.
- out_valid  output  1  output beat valid.
- out_data  output  DATA_W  output payload, selected by sel.
- out_ready  input  1  consumer accepts beat.
- sel  output  1  registered grant: 0 = requester 0, 1 = requester 1.
- busy  output  1  high when the state is GRANT0 or GRANT1.

Behaviour:
- Reset: one clock; reset is synchronous and active-high (ports clk, reset).
- On a clock edge with reset high:
  - state = IDLE, prio = 0 (requester 0 preferred), beat_cnt = 0, sel = 0.
  - While reset is high, out_valid, in0_ready, in1_ready and busy are forced to 0 combinationally, and out_data = in0_data.
- State register is 2 bits: IDLE, GRANT0, GRANT1. sel = 1 only in GRANT1; it is held at its last value in IDLE.
- IDLE:
  - out_valid = 0; both readys = 0.
  - Only in1_valid → GRANT1.
  - Only in0_valid → GRANT0.
  - Both valid → GRANTprio.
  - Neither valid → stay in IDLE.
  - Grant latency is exactly 1 cycle from valid to the first possible accept.
- GRANTn:
  - out_valid = inN_valid, out_data = inN_data, inN_ready = out_ready; the other ready = 0.
  - A beat transfers when inN_valid and out_ready are both high; each transfer increments beat_cnt.
- Release from GRANTn happens on either condition:
  - (a) a transfer occurs with beat_cnt == MAX_BURST-1, or
  - (b) inN_valid is low in that cycle (requester idle).
- On release:
  - beat_cnt resets to 0 and prio = the other requester.
  - If the other requester's valid is high → go directly to GRANTother, with no IDLE bubble.
  - Otherwise → IDLE.
- A stalled beat (out_ready low) holds the grant indefinitely, with no timeout and no rotation.
- MAX_BURST = 1: every accepted beat forces rotation; two continuously valid requesters alternate 0,1,0,1.
- A requester that drops valid mid-burst loses the grant after that cycle; the burst count does not carry over.
- Sources must keep data stable while valid && !ready; the arbiter does not check this.
- No combinational path from out_ready to sel.
- Synchronous reset mid-burst: the beat in flight that cycle is not accepted (ready forced low); all state returns to reset values.

Optional Feature:
- Macro: MUX_RR_ARB_STATS_EN.
- Defined:
  - Adds output ports beats0 and beats1, each CNT_W wide, counting accepted beats per requester.
  - Counters saturate at all-ones.
  - Cleared by reset.
  - Updated on the same edge as the transfer, so they are visible the next cycle.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then only in0_valid=1, in0_data=0xA5, out_ready=1 → cycle 1 state GRANT0, out_data=0xA5, in0_ready=1; after 4 beats release, state IDLE then GRANT0 again (1-cycle bubble), sel=0.
- Both valid continuously, out_ready=1, MAX_BURST=4 → beats from requester 0 ×4, then 1 ×4, then 0 ×4; no bubble at the switches; sel toggles every 4 cycles.
- Both valid from reset → first grant to requester 0 (prio=0); then in0 drops valid after 2 beats → next cycle GRANT1, prio=1.
- GRANT1 with out_ready=0 for 10 cycles while in0_valid=1 → sel stays 1, in0_ready=0, beat_cnt unchanged; out_ready=1 resumes the burst.
- Reset asserted during the 3rd beat of GRANT0 with out_ready=1 → in0_ready=0 that cycle; next cycle state IDLE, beat_cnt=0, sel=0.
- With MUX_RR_ARB_STATS_EN and CNT_W=4: 20 beats from requester 1 → beats1 saturates at 15, beats0 = 0.
